// File: rtl/wb_trace_writer_pkg.sv
// Shared types for the writeback-trace writer: record kinds, packed record layout, serializer states.
package wb_trace_writer_pkg;

    typedef enum logic [1:0] {
        TRACE_SKIP = 2'd0,
        TRACE_REG  = 2'd1,
        TRACE_HILO = 2'd2,
        TRACE_CP0  = 2'd3
    } trace_kind_t;

    // Field order is the wire order: the 96-bit record is the 12-byte packet, MSB first.
    typedef struct packed {
        trace_kind_t kind;
        logic        ovf;
        logic [4:0]  addr;
        logic [23:0] idx;
        logic [31:0] d0;
        logic [31:0] d1;
    } trace_rec_t;

    localparam int TRACE_PKT_BYTES = 12;
    localparam int TRACE_REC_BITS  = $bits(trace_rec_t);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/wb_trace_writer_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored.
module wb_trace_writer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_en   = push && !full;
    assign rd_en   = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_writer.sv
// Writeback-trace writer: tags each CPU writeback cycle, buffers records, streams 12-byte packets.
// Latency: event cycle +2 to first tx_valid when idle and empty; back-to-back packets without bubbles.
// Backpressure: tx_ready low holds tx_data/tx_valid; a full FIFO drops records and counts them.
module wb_trace_writer
    import wb_trace_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int WARMUP     = 5,
    parameter bit SKIP_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_en,
    input  logic        reg_we,
    input  logic [4:0]  reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        hilo_we,
    input  logic [31:0] hi_data,
    input  logic [31:0] lo_data,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [15:0] drop_count
);
    localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LAST_BYTE = 4'(TRACE_PKT_BYTES - 1);

    logic [WW-1:0]   warm_cnt;
    logic [23:0]     idx_cnt;
    logic            capture;
    trace_rec_t      rec;
    logic            rec_vld;
    logic            ovf_pend;
    logic            push;
    logic            drop;

    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt;
    logic [TRACE_REC_BITS-1:0]       head_dat;
    logic [TRACE_PKT_BYTES-1:0][7:0] head_bytes;

    tx_state_t       state;
    tx_state_t       state_nxt;
    logic [3:0]      byte_idx;
    logic [3:0]      byte_nxt;

    assign capture = trace_en && (warm_cnt == WW'(WARMUP));

    // Dropping trace_en clears both counters, so a later rising edge restarts warmup and idx.
    always_ff @(posedge clk) begin
        if (!rst || !trace_en) begin
            warm_cnt <= '0;
            idx_cnt  <= '0;
        end else if (!capture) begin
            warm_cnt <= warm_cnt + WW'(1);
        end else begin
            idx_cnt <= idx_cnt + 24'd1;
        end
    end

    always_comb begin
        rec      = '0;
        rec.kind = TRACE_SKIP;
        rec.ovf  = ovf_pend;
        rec.idx  = idx_cnt + 24'd1;
        if (reg_we) begin
            rec.kind = TRACE_REG;
            rec.addr = reg_waddr;
            rec.d0   = reg_wdata;
        end else if (hilo_we) begin
            rec.kind = TRACE_HILO;
            rec.d0   = hi_data;
            rec.d1   = lo_data;
        end else if (cp0_we) begin
            rec.kind = TRACE_CP0;
            rec.addr = cp0_waddr;
            rec.d0   = cp0_wdata;
        end
    end

    assign rec_vld = capture && (SKIP_EN || (rec.kind != TRACE_SKIP));
    assign push    = rec_vld && !fifo_full;
    assign drop    = rec_vld && fifo_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_pend   <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop) begin
                ovf_pend <= 1'b1;
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if (push) begin
                ovf_pend <= 1'b0;
            end
        end
    end

    wb_trace_writer_fifo #(
        .WIDTH (TRACE_REC_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (rec),
        .pop      (fifo_pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // The packet is read in place from the FIFO head and only popped after its last byte,
    // so the in-flight packet occupies a FIFO slot until it has fully left.
    assign head_bytes = head_dat;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= TX_IDLE;
            byte_idx <= '0;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        byte_nxt  = byte_idx;
        fifo_pop  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = TX_SEND;
                    byte_nxt  = '0;
                end
            end
            TX_SEND: begin
                tx_valid = 1'b1;
                tx_data  = head_bytes[LAST_BYTE - byte_idx];
                if (tx_ready) begin
                    if (byte_idx == LAST_BYTE) begin
                        fifo_pop = 1'b1;
                        byte_nxt = '0;
                        if (!((fifo_cnt > CW'(1)) || push)) state_nxt = TX_IDLE;
                    end else begin
                        byte_nxt = byte_idx + 4'd1;
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_trace_writer.sv
// Scenario bench for wb_trace_writer: stimulus pushes expected packet bytes, a monitor pops and compares.
module tb_wb_trace_writer;
    localparam int WARMUP = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trace_en = 1'b0;
    logic        reg_we = 1'b0;
    logic [4:0]  reg_waddr = '0;
    logic [31:0] reg_wdata = '0;
    logic        hilo_we = 1'b0;
    logic [31:0] hi_data = '0;
    logic [31:0] lo_data = '0;
    logic        cp0_we = 1'b0;
    logic [4:0]  cp0_waddr = '0;
    logic [31:0] cp0_wdata = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        overflow;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    wb_trace_writer #(
        .FIFO_DEPTH (16),
        .WARMUP     (WARMUP),
        .SKIP_EN    (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trace_en   (trace_en),
        .reg_we     (reg_we),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .hilo_we    (hilo_we),
        .hi_data    (hi_data),
        .lo_data    (lo_data),
        .cp0_we     (cp0_we),
        .cp0_waddr  (cp0_waddr),
        .cp0_wdata  (cp0_wdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    int         checks = 0;
    int         errors = 0;
    int         acc_cnt = 0;
    logic [7:0] exp_q[$];
    logic       held = 1'b0;
    logic [7:0] held_dat = '0;

    int          m_warm = 0;
    logic [23:0] m_idx = '0;
    logic        m_ovf = 1'b0;

    // Monitor: every accepted byte is popped from the expected queue; stalled bytes must hold.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== held_dat) begin
                    errors++;
                    $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, held_dat);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                acc_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_byte: got %h, required no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL byte%0d: got %h, required %h", acc_cnt, tx_data, e);
                    end
                end
            end
            held     = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
            held_dat = tx_data;
        end
    end

    task automatic push_pkt(input logic [1:0] k, input logic ovf, input logic [4:0] a,
                            input logic [23:0] idx, input logic [31:0] d0, input logic [31:0] d1);
        exp_q.push_back({k, ovf, a});
        exp_q.push_back(idx[23:16]); exp_q.push_back(idx[15:8]); exp_q.push_back(idx[7:0]);
        exp_q.push_back(d0[31:24]);  exp_q.push_back(d0[23:16]); exp_q.push_back(d0[15:8]); exp_q.push_back(d0[7:0]);
        exp_q.push_back(d1[31:24]);  exp_q.push_back(d1[23:16]); exp_q.push_back(d1[15:8]); exp_q.push_back(d1[7:0]);
    endtask

    // One input cycle; keep=0 means the bench expects this record to be dropped.
    task automatic drive(input logic en, input logic rwe, input logic [4:0] ra, input logic [31:0] rd,
                         input logic hwe, input logic [31:0] hi, input logic [31:0] lo,
                         input logic cwe, input logic [4:0] ca, input logic [31:0] cd, input bit keep);
        logic [1:0]  k;
        logic [4:0]  a;
        logic [31:0] d0;
        logic [31:0] d1;
        trace_en = en; reg_we = rwe; reg_waddr = ra; reg_wdata = rd;
        hilo_we = hwe; hi_data = hi; lo_data = lo;
        cp0_we = cwe; cp0_waddr = ca; cp0_wdata = cd;
        if (!en) begin
            m_warm = 0;
            m_idx  = '0;
        end else if (m_warm < WARMUP) begin
            m_warm++;
        end else begin
            m_idx = m_idx + 24'd1;
            if (rwe)      begin k = 2'd1; a = ra;   d0 = rd;    d1 = '0; end
            else if (hwe) begin k = 2'd2; a = '0;   d0 = hi;    d1 = lo; end
            else if (cwe) begin k = 2'd3; a = ca;   d0 = cd;    d1 = '0; end
            else          begin k = 2'd0; a = '0;   d0 = '0;    d1 = '0; end
            if (keep) begin
                push_pkt(k, m_ovf, a, m_idx, d0, d1);
                m_ovf = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic en, input bit keep);
        drive(en, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, keep);
    endtask

    task automatic reg_wr(input logic [4:0] ra, input logic [31:0] rd);
        drive(1'b1, 1'b1, ra, rd, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic start_trace();
        repeat (WARMUP) idle(1'b1, 1'b1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int vcnt;
        rst = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b, required 0", tx_valid); end
        checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL reset_data: got %h, required 00", tx_data); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drops: got %0d, required 0", drop_count); end
        rst = 1'b1;
        vcnt = 0;
        repeat (10) begin
            idle(1'b0, 1'b1);
            if (tx_valid !== 1'b0) vcnt++;
        end
        checks++; if (vcnt != 0) begin errors++; $display("FAIL idle_no_bytes: %0d valid cycles, required 0", vcnt); end
    endtask

    task automatic test_single_reg();
        tx_ready = 1'b1;
        start_trace();
        reg_wr(5'd3, 32'h0000_ABCD);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL latency_e1: valid=%b, required 0", tx_valid); end
        idle(1'b0, 1'b1);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL latency_e2: valid=%b, required 1", tx_valid); end
        wait_drain("single", 100);
    endtask

    task automatic test_priority();
        tx_ready = 1'b1;
        start_trace();
        idle(1'b1, 1'b1);
        drive(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 32'hAAAA, 32'hBBBB, 1'b1, 5'd12, 32'hCCCC, 1'b1);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 32'h1, 32'h2, 1'b0, '0, '0, 1'b1);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12, 32'h0000_0401, 1'b1);
        idle(1'b0, 1'b1);
        wait_drain("priority", 200);
    endtask

    task automatic test_backpressure();
        tx_ready = 1'b0;
        start_trace();
        reg_wr(5'd5, 32'hDEAD_BEEF);
        reg_wr(5'd6, 32'h1234_5678);
        idle(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tx_ready = ~tx_ready;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        wait_drain("backpressure", 10);
    endtask

    task automatic test_back_to_back();
        int vcnt;
        tx_ready = 1'b0;
        start_trace();
        reg_wr(5'd9, 32'h0102_0304);
        reg_wr(5'd10, 32'hA0B0_C0D0);
        idle(1'b0, 1'b1);
        repeat (3) idle(1'b0, 1'b1);
        tx_ready = 1'b1;
        vcnt = 0;
        repeat (24) begin
            @(negedge clk);
            if (tx_valid === 1'b1) vcnt++;
        end
        checks++; if (vcnt != 24) begin errors++; $display("FAIL b2b_no_bubble: %0d valid cycles, required 24", vcnt); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: valid=%b, required 0", tx_valid); end
        wait_drain("b2b", 10);
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        start_trace();
        for (int i = 0; i < 20; i++) idle(1'b1, (i < 16));
        idle(1'b0, 1'b1);
        checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drops: got %0d, required 4", drop_count); end
        checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        tx_ready = 1'b1;
        wait_drain("ovf_release", 400);
        start_trace();
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        wait_drain("ovf_marked", 100);
        checks++; if (overflow !== 1'b1 || drop_count !== 16'd4) begin
            errors++; $display("FAIL ovf_sticky: overflow=%b drops=%0d, required 1 and 4", overflow, drop_count);
        end
    endtask

    task automatic test_midreset();
        int base;
        tx_ready = 1'b1;
        base = acc_cnt;
        start_trace();
        reg_wr(5'd7, 32'hCAFE_F00D);
        idle(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (acc_cnt >= base + 5) break;
            @(posedge clk);
            #1;
        end
        checks++; if (acc_cnt != base + 5) begin errors++; $display("FAIL midrst_reach: accepted %0d, required 5", acc_cnt - base); end
        tx_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0)    begin errors++; $display("FAIL midrst_valid: got %b, required 0", tx_valid); end
        checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL midrst_data: got %h, required 00", tx_data); end
        checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            errors++; $display("FAIL midrst_status: overflow=%b drops=%0d, required 0 and 0", overflow, drop_count);
        end
        exp_q.delete();
        rst = 1'b1;
        tx_ready = 1'b1;
        base = acc_cnt;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (acc_cnt != base || tx_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_residual: %0d bytes valid=%b, required 0 bytes valid=0", acc_cnt - base, tx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_reg();
        test_priority();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
